// File: rtl/common_pkg.sv
// Shared PS/2 types and constants.
// Used by the host transmitter and the receiver.
package common;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    BITS,
    ACK,
    WAITREL,
    DONE,
    FAIL
  } ps2tx_state_t;

  localparam logic [7:0] PS2_CMD_LEDS      = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET     = 8'hFF;
  localparam logic [7:0] PS2_CMD_TYPEMATIC = 8'hF3;

  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

  function automatic int unsigned us_to_cycles(
    input int unsigned us,
    input int unsigned hz
  );
    return int'((64'(us) * 64'(hz)) / 64'd1_000_000);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pin conditioner: 2-FF sync, 3-sample
// glitch filter and 1-cycle falling-edge strobe.
module ps2_line_filter (
  input  logic clk28,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic [1:0] sync;
  logic [2:0] hist;

  // Lines idle high, so everything resets to 1.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= 2'b11;
      hist  <= 3'b111;
      level <= 1'b1;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], pin};
      hist <= {hist[1:0], sync[1]};
      fall <= level && (hist == 3'b000);
      if (hist == 3'b111)
        level <= 1'b1;
      else if (hist == 3'b000)
        level <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter.
// Open-drain drive via *_oe; top builds tristates.
module ps2_host_tx
  import common::*;
#(
  parameter int CLK_FREQ   = 28_000_000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15_000
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       rx_inhibit,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_CYC =
    us_to_cycles(INHIBIT_US, CLK_FREQ);
  localparam int unsigned TO_CYC =
    us_to_cycles(TIMEOUT_US, CLK_FREQ);
  localparam int INH_W = $clog2(INH_CYC + 1);
  localparam int TO_W  = $clog2(TO_CYC + 1);

  localparam logic [INH_W-1:0] INH_LOAD =
    INH_W'(INH_CYC - 1);
  localparam logic [INH_W-1:0] INH_ONE = 1;
  localparam logic [TO_W-1:0]  TO_LOAD =
    TO_W'(TO_CYC - 1);
  localparam logic [TO_W-1:0]  TO_ONE = 1;

  ps2tx_state_t     state_q, state_d;
  logic [9:0]       shift_q, shift_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             dat_q, dat_d;
  logic             tail_q;

  logic clk_lvl, clk_fall;
  logic dat_lvl, dat_fall_unused;

  ps2_line_filter u_clk_filt (
    .clk28 (clk28),
    .rst_n (rst_n),
    .pin   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_line_filter u_dat_filt (
    .clk28 (clk28),
    .rst_n (rst_n),
    .pin   (ps2_dat_in),
    .level (dat_lvl),
    .fall  (dat_fall_unused)
  );

  // State, shifter, counters; async reset drops both lines.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bcnt_q  <= '0;
      inh_q   <= '0;
      to_q    <= '0;
      dat_q   <= 1'b0;
      tail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcnt_q  <= bcnt_d;
      inh_q   <= inh_d;
      to_q    <= to_d;
      dat_q   <= dat_d;
      tail_q  <= (state_q == DONE) ||
                 (state_q == FAIL);
    end
  end

  // Next state and line/handshake outputs.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    inh_d      = inh_q;
    to_d       = to_q;
    dat_d      = dat_q;
    tx_ready   = 1'b0;
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        dat_d    = 1'b0;
        if (tx_valid) begin
          shift_d = {1'b1, odd_parity(tx_data),
                     tx_data};
          inh_d   = INH_LOAD;
          bcnt_d  = '0;
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (inh_q == '0)
          state_d = RTS;
        else
          inh_d = inh_q - INH_ONE;
      end
      RTS: begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = 1'b1;
        dat_d      = 1'b1;
        to_d       = TO_LOAD;
        state_d    = BITS;
      end
      BITS: begin
        ps2_dat_oe = dat_q;
        if (to_q == '0) begin
          state_d = FAIL;
        end else begin
          to_d = to_q - TO_ONE;
          if (clk_fall) begin
            dat_d   = ~shift_q[0];
            shift_d = {1'b0, shift_q[9:1]};
            bcnt_d  = bcnt_q + 4'd1;
            if (bcnt_q == 4'd9)
              state_d = ACK;
          end
        end
      end
      ACK: begin
        if (to_q == '0) begin
          state_d = FAIL;
        end else begin
          to_d = to_q - TO_ONE;
          if (clk_fall)
            state_d = dat_lvl ? FAIL : WAITREL;
        end
      end
      WAITREL: begin
        if (to_q == '0) begin
          state_d = FAIL;
        end else begin
          to_d = to_q - TO_ONE;
          if (clk_lvl && dat_lvl)
            state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      FAIL: begin
        error   = 1'b1;
        dat_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Hold off the receiver one extra cycle past DONE/FAIL.
  assign rx_inhibit = (state_q != IDLE) || tail_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a PS/2 device model.
// Device clock is sped up to keep frames short.
module tb_ps2_host_tx;

  localparam int CLK_FREQ = 28_000_000;
  localparam int INH_US   = 100;
  localparam int TO_US    = 500;
  localparam int INH_CYC  = 2800;
  localparam int TO_CYC   = 14000;
  localparam int HALF     = 100;

  logic       clk28 = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       rx_inhibit;
  logic       done;
  logic       error;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       clk_line;
  logic       dat_line;

  assign clk_line = dev_clk & ~ps2_clk_oe;
  assign dat_line = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .CLK_FREQ   (CLK_FREQ),
    .INHIBIT_US (INH_US),
    .TIMEOUT_US (TO_US)
  ) dut (
    .clk28      (clk28),
    .rst_n      (rst_n),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .rx_inhibit (rx_inhibit),
    .done       (done),
    .error      (error)
  );

  always #5 clk28 = ~clk28;

  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(posedge clk28) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (error) err_cnt <= err_cnt + 1;
  end

  logic ready_q = 1'b1;
  logic rose_inh = 1'b0;
  logic post_inh = 1'b1;
  logic post_pend = 1'b0;

  always @(negedge clk28) begin
    ready_q <= tx_ready;
    if (tx_ready && !ready_q) begin
      rose_inh  <= rx_inhibit;
      post_pend <= 1'b1;
    end else if (post_pend) begin
      post_inh  <= rx_inhibit;
      post_pend <= 1'b0;
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int k = 0;
    @(negedge clk28);
    while (!tx_ready && k < 20000) begin
      @(negedge clk28);
      k++;
    end
    if (!tx_ready) chk("send_ready", 0, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk28);
    #1 tx_valid = 1'b0;
  endtask

  task automatic dev_rx(input bit ack,
                        input int stop_after,
                        output logic [10:0] fr);
    int k = 0;
    fr = '0;
    @(negedge clk28);
    while (!(ps2_dat_oe && !ps2_clk_oe)
           && k < 10000) begin
      @(negedge clk28);
      k++;
    end
    if (!(ps2_dat_oe && !ps2_clk_oe)) begin
      chk("dev_request", 0, 1);
      return;
    end
    repeat (HALF) @(negedge clk28);
    fr[0] = dat_line;
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk28);
      dev_clk = 1'b1;
      fr[i] = dat_line;
      if (i == stop_after) return;
      repeat (HALF) @(negedge clk28);
    end
    if (ack) dev_dat = 1'b0;
    repeat (HALF / 2) @(negedge clk28);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk28);
    dev_clk = 1'b1;
    repeat (HALF / 2) @(negedge clk28);
    dev_dat = 1'b1;
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk28);
    while (!tx_ready && k < 20000) begin
      @(negedge clk28);
      k++;
    end
    if (!tx_ready) chk("wait_idle", 0, 1);
    repeat (2) @(negedge clk28);
  endtask

  typedef struct {
    logic [7:0]  data;
    bit          ack;
    logic [10:0] frame;
    int          d_done;
    int          d_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [10:0] fr;
    int d0, e0, k, cnt, bad, c0;

    vecs[0] = '{8'hED, 1'b1, 11'b1_1_11101101_0, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 11'b1_1_00000000_0, 1, 0};
    vecs[2] = '{8'h01, 1'b1, 11'b1_0_00000001_0, 1, 0};
    vecs[3] = '{8'hA5, 1'b1, 11'b1_1_10100101_0, 1, 0};
    vecs[4] = '{8'hED, 1'b0, 11'b1_1_11101101_0, 0, 1};

    repeat (5) @(negedge clk28);
    chk("rst_ready", tx_ready, 1);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_inhibit", rx_inhibit, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk28);

    for (int v = 0; v < 5; v++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(vecs[v].data);
      dev_rx(vecs[v].ack, 0, fr);
      wait_idle();
      chk($sformatf("v%0d_frame", v), fr,
          vecs[v].frame);
      chk($sformatf("v%0d_done", v),
          done_cnt - d0, vecs[v].d_done);
      chk($sformatf("v%0d_err", v),
          err_cnt - e0, vecs[v].d_err);
      chk($sformatf("v%0d_inh_tail", v),
          rose_inh, 1);
      chk($sformatf("v%0d_inh_off", v),
          post_inh, 0);
      chk($sformatf("v%0d_lines", v),
          {ps2_clk_oe, ps2_dat_oe}, 0);
    end

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h55);
    cnt = 0;
    bad = 0;
    k = 0;
    @(negedge clk28);
    while (!ps2_dat_oe && k < 10000) begin
      if (ps2_clk_oe) cnt++;
      if (tx_ready) bad++;
      @(negedge clk28);
      k++;
    end
    chk("inh_cycles", cnt, INH_CYC);
    chk("inh_ready_low", bad, 0);
    chk("rts_clk_oe", ps2_clk_oe, 1);
    k = 0;
    while (ps2_clk_oe && k < 10) begin
      @(negedge clk28);
      k++;
    end
    c0 = cyc;
    k = 0;
    while (!error && k < 20000) begin
      @(negedge clk28);
      k++;
    end
    chk("to_seen", error, 1);
    chk("to_in_window",
        ((cyc - c0) >= TO_CYC - 1) &&
        ((cyc - c0) <= TO_CYC + 1), 1);
    chk("to_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
    @(negedge clk28);
    chk("to_ready", tx_ready, 1);
    chk("to_no_done", done_cnt - d0, 0);

    send(8'h00);
    dev_rx(1'b1, 4, fr);
    @(negedge clk28);
    chk("mid_dat_oe", ps2_dat_oe, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lines", {ps2_clk_oe, ps2_dat_oe}, 0);
    chk("arst_ready", tx_ready, 1);
    repeat (3) @(negedge clk28);
    rst_n = 1'b1;
    repeat (3) @(negedge clk28);

    send(8'hF3);
    repeat (100) @(negedge clk28);
    chk("inh_clk_oe", ps2_clk_oe, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_inh_clk", ps2_clk_oe, 0);
    repeat (3) @(negedge clk28);
    rst_n = 1'b1;
    repeat (3) @(negedge clk28);

    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hFF);
    repeat (50) @(negedge clk28);
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    @(posedge clk28);
    #1 tx_valid = 1'b0;
    dev_rx(1'b1, 0, fr);
    wait_idle();
    chk("ff_frame", fr, 11'b1_1_11111111_0);
    chk("ff_done", done_cnt - d0, 1);
    chk("ff_err", err_cnt - e0, 0);
    repeat (10) @(negedge clk28);
    chk("busy_ignored", {tx_ready, ps2_clk_oe},
        2'b10);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
